// File: rtl/mhp_pkg.sv
// mhp_pkg: shared types and constants for the MHP frame engine.
// FSM states, header field codes and reply layout.
package mhp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_CAP,
    RD_GAP,
    PARSE,
    TX_FETCH,
    TX_LOAD,
    TX_SEND,
    TX_END
  } state_t;

  localparam logic [6:0]  TYPE_PING      = 7'h01;
  localparam logic [6:0]  TYPE_REQ_ADDR  = 7'h03;
  localparam int          DIR_REPLY      = 7;
  localparam logic [15:0] BCAST_ADDR     = 16'hFFFF;
  localparam int          HDR_LEN        = 5;
  localparam int          REQ_REPLY_LEN  = 9;
  localparam logic [7:0]  REQ_REPLY_TYPE = 8'h83;

  // Byte i of the fixed-layout REQ_ADDR reply.
  function automatic logic [7:0] req_reply_byte(
    input logic [3:0]  i,
    input logic [15:0] src,
    input logic [15:0] node
  );
    logic [7:0] b;
    b = 8'h00;
    case (i)
      4'd0:    b = src[15:8];
      4'd1:    b = src[7:0];
      4'd2:    b = node[15:8];
      4'd3:    b = node[7:0];
      4'd4:    b = REQ_REPLY_TYPE;
      4'd5:    b = 8'h00;
      4'd6:    b = 8'h02;
      4'd7:    b = node[15:8];
      4'd8:    b = node[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/mhp_byte_ram.sv
// mhp_byte_ram: single-port byte RAM, one-cycle registered read.
// Depth is 2**AW bytes.
module mhp_byte_ram #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);

  logic [7:0] mem [2**AW];

  // Write on we; read data registered every cycle.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mhp_frame_engine.sv
// mhp_frame_engine: drains an RX payload, parses the MHP header, replies.
// Optional UART tap mirror of TX enabled by macro MHP_UART_TAP_EN.
module mhp_frame_engine
  import mhp_pkg::*;
#(
  parameter int          BUF_AW    = 10,
  parameter int          IDLE_GAP  = 63,
  parameter logic [15:0] NODE_ADDR = 16'h0001,
  parameter int          MIN_LEN   = 5
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_rdata,
  input  logic        i_rready,
  output logic        o_rreq,
  output logic [7:0]  o_wdata,
  input  logic        i_wready,
  output logic        o_wvalid,
  output logic        o_wvalid_u,
  output logic [7:0]  o_wdata_u,
  output logic        o_done,
  output logic        o_busy,
  output logic [15:0] o_frame_cnt,
  output logic [7:0]  o_drop_cnt
);

  localparam logic [BUF_AW:0] LEN_MIN = (BUF_AW+1)'(MIN_LEN);
  localparam logic [BUF_AW:0] LEN_HDR = (BUF_AW+1)'(HDR_LEN);
  localparam logic [BUF_AW:0] LEN_REQ = (BUF_AW+1)'(REQ_REPLY_LEN);
  localparam logic [7:0]      GAP_END = 8'(IDLE_GAP);

  state_t            state, state_nx;
  logic [BUF_AW:0]   len, idx, idx_inc, tx_len;
  logic              ovf, is_ping, accept, last, ram_we;
  logic [7:0]        gap, gap_inc, typ, tx_byte, ram_rdata;
  logic [15:0]       dst, src;
  logic [BUF_AW-1:0] ram_addr;

  assign idx_inc  = idx + 1'b1;
  assign gap_inc  = gap + 8'd1;
  assign is_ping  = typ[6:0] == TYPE_PING;
  assign tx_len   = is_ping ? len : LEN_REQ;
  assign last     = idx_inc == tx_len;
  assign o_busy   = state != IDLE;
  assign accept   = !ovf && len >= LEN_MIN && !typ[DIR_REPLY]
                 && (dst == NODE_ADDR || dst == BCAST_ADDR)
                 && (is_ping || typ[6:0] == TYPE_REQ_ADDR);
  // len's top bit is set only once the buffer is full.
  assign ram_we   = state == RD_CAP && !len[BUF_AW] && !i_rst;
  assign ram_addr = state == RD_CAP ? len[BUF_AW-1:0]
                                    : idx[BUF_AW-1:0];

  mhp_byte_ram #(.AW(BUF_AW)) u_ram (
    .clk   (i_clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (i_rdata),
    .rdata (ram_rdata)
  );

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nx;
  end

  // Next state and single-cycle strobes.
  always_comb begin
    state_nx = state;
    o_rreq   = 1'b0;
    o_wvalid = 1'b0;
    o_done   = 1'b0;
    if (!i_rst) begin
      unique case (state)
        IDLE: if (i_rready) begin
          o_rreq   = 1'b1;
          state_nx = RD_CAP;
        end
        RD_CAP: state_nx = RD_GAP;
        RD_GAP: begin
          if (i_rready) begin
            o_rreq   = 1'b1;
            state_nx = RD_CAP;
          end else if (gap_inc == GAP_END) begin
            state_nx = PARSE;
          end
        end
        PARSE:    state_nx = accept ? TX_FETCH : IDLE;
        TX_FETCH: state_nx = TX_LOAD;
        TX_LOAD:  state_nx = TX_SEND;
        TX_SEND: if (i_wready) begin
          o_wvalid = 1'b1;
          state_nx = last ? TX_END : TX_FETCH;
        end
        TX_END: begin
          o_done   = 1'b1;
          state_nx = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // Outgoing byte: rewritten header, fixed reply, or buffered payload.
  always_comb begin
    tx_byte = ram_rdata;
    if (!is_ping) begin
      tx_byte = req_reply_byte(idx[3:0], src, NODE_ADDR);
    end else if (idx < LEN_HDR) begin
      unique case (idx[2:0])
        3'd0:    tx_byte = src[15:8];
        3'd1:    tx_byte = src[7:0];
        3'd2:    tx_byte = NODE_ADDR[15:8];
        3'd3:    tx_byte = NODE_ADDR[7:0];
        default: tx_byte = typ | 8'h80;
      endcase
    end
  end

  // Capture, gap counting, header fields, TX byte and statistics.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      len         <= '0;
      idx         <= '0;
      ovf         <= 1'b0;
      gap         <= 8'd0;
      dst         <= 16'd0;
      src         <= 16'd0;
      typ         <= 8'd0;
      o_wdata     <= 8'd0;
      o_frame_cnt <= 16'd0;
      o_drop_cnt  <= 8'd0;
    end else begin
      unique case (state)
        IDLE: begin
          len <= '0;
          idx <= '0;
          ovf <= 1'b0;
        end
        RD_CAP: begin
          gap <= 8'd0;
          if (len[BUF_AW]) ovf <= 1'b1;
          else             len <= len + 1'b1;
          if (len < LEN_HDR) begin
            unique case (len[2:0])
              3'd0:    dst[15:8] <= i_rdata;
              3'd1:    dst[7:0]  <= i_rdata;
              3'd2:    src[15:8] <= i_rdata;
              3'd3:    src[7:0]  <= i_rdata;
              default: typ       <= i_rdata;
            endcase
          end
        end
        RD_GAP: if (!i_rready) gap <= gap_inc;
        PARSE: begin
          if (accept)                  o_frame_cnt <= o_frame_cnt + 16'd1;
          else if (o_drop_cnt != 8'hFF) o_drop_cnt <= o_drop_cnt + 8'd1;
        end
        TX_LOAD: o_wdata <= tx_byte;
        TX_SEND: if (i_wready) idx <= idx_inc;
        default: ;
      endcase
    end
  end

`ifdef MHP_UART_TAP_EN
  assign o_wvalid_u = o_wvalid;
  assign o_wdata_u  = o_wdata;
`else
  assign o_wvalid_u = 1'b0;
  assign o_wdata_u  = 8'h00;
`endif

endmodule

// File: tb/tb_mhp_frame_engine.sv
// tb_mhp_frame_engine: directed and random frames against a frame-level
// reference model; RX FIFO and TX sink modelled in the bench.
module tb_mhp_frame_engine;

  localparam int          AW   = 4;
  localparam int          GAP  = 8;
  localparam logic [15:0] NODE = 16'h0001;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [7:0]  i_rdata;
  logic        i_rready;
  logic        o_rreq;
  logic [7:0]  o_wdata;
  logic        i_wready;
  logic        o_wvalid;
  logic        o_wvalid_u;
  logic [7:0]  o_wdata_u;
  logic        o_done;
  logic        o_busy;
  logic [15:0] o_frame_cnt;
  logic [7:0]  o_drop_cnt;

  always #5 i_clk = ~i_clk;

  mhp_frame_engine #(
    .BUF_AW(AW), .IDLE_GAP(GAP), .NODE_ADDR(NODE), .MIN_LEN(5)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_rdata(i_rdata),
    .i_rready(i_rready), .o_rreq(o_rreq), .o_wdata(o_wdata),
    .i_wready(i_wready), .o_wvalid(o_wvalid),
    .o_wvalid_u(o_wvalid_u), .o_wdata_u(o_wdata_u),
    .o_done(o_done), .o_busy(o_busy),
    .o_frame_cnt(o_frame_cnt), .o_drop_cnt(o_drop_cnt)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0]  rxq[$];
  logic [7:0]  txq[$];
  logic [7:0]  fr[$];
  logic [7:0]  exp_q[$];
  int          rx_n = 0;
  logic        rx_en = 1'b1;
  logic        pend = 1'b0;
  logic        prev_wv = 1'b0;
  int          pops = 0;
  int          dones = 0;
  int          b2b = 0;
  int          tap_bad = 0;
  int          d0, p0;
  bit          exp_acc;
  logic [15:0] exp_frame = 16'd0;
  logic [7:0]  exp_drop = 8'd0;
  logic [15:0] node_v = NODE;

  assign i_rready = rx_en && (rx_n != 0);

  // RX FIFO: a pop seen in one cycle delivers data in the next.
  // TX sink, done counter and tap monitor.
  always @(negedge i_clk) begin
    if (pend && rxq.size() != 0) begin
      i_rdata = rxq.pop_front();
      rx_n--;
      pops++;
    end
    pend = o_rreq;
    if (o_wvalid) begin
      txq.push_back(o_wdata);
      if (prev_wv) b2b++;
    end
    prev_wv = o_wvalid;
    if (o_done) dones++;
`ifdef MHP_UART_TAP_EN
    if (o_wvalid_u !== o_wvalid || o_wdata_u !== o_wdata) tap_bad++;
`else
    if (o_wvalid_u !== 1'b0 || o_wdata_u !== 8'h00) tap_bad++;
`endif
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_hex(input logic [127:0] v, input int n);
    fr.delete();
    for (int i = 0; i < n; i++) fr.push_back(v[8*(n-1-i) +: 8]);
  endtask

  // Frame-level reference: which frames are accepted and what they return.
  task automatic build_expect();
    int n;
    logic [15:0] dst, src;
    logic [7:0] ty;
    n = fr.size();
    exp_q.delete();
    exp_acc = 1'b0;
    if (n < 5 || n > 2**AW) return;
    dst = {fr[0], fr[1]};
    src = {fr[2], fr[3]};
    ty  = fr[4];
    if (ty[7]) return;
    if (dst != node_v && dst != 16'hFFFF) return;
    if (ty[6:0] == 7'h01) begin
      exp_acc = 1'b1;
      exp_q.push_back(src[15:8]);
      exp_q.push_back(src[7:0]);
      exp_q.push_back(node_v[15:8]);
      exp_q.push_back(node_v[7:0]);
      exp_q.push_back(ty | 8'h80);
      for (int i = 5; i < n; i++) exp_q.push_back(fr[i]);
    end else if (ty[6:0] == 7'h03) begin
      exp_acc = 1'b1;
      exp_q.push_back(src[15:8]);
      exp_q.push_back(src[7:0]);
      exp_q.push_back(node_v[15:8]);
      exp_q.push_back(node_v[7:0]);
      exp_q.push_back(8'h83);
      exp_q.push_back(8'h00);
      exp_q.push_back(8'h02);
      exp_q.push_back(node_v[15:8]);
      exp_q.push_back(node_v[7:0]);
    end
  endtask

  task automatic start_frame();
    build_expect();
    txq.delete();
    d0  = dones;
    p0  = pops;
    b2b = 0;
    foreach (fr[i]) rxq.push_back(fr[i]);
    rx_n += fr.size();
  endtask

  task automatic finish_frame(input string tag);
    int k;
    k = 0;
    do begin
      @(negedge i_clk);
      k++;
    end while (!(rx_n == 0 && !o_busy && !pend) && k < 4000);
    chk({tag, "_idle"}, 32'(k < 4000), 32'(1));
    if (exp_acc) exp_frame++;
    else if (exp_drop != 8'hFF) exp_drop++;
    chk({tag, "_pops"}, 32'(pops - p0), 32'(fr.size()));
    chk({tag, "_txlen"}, 32'(txq.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < txq.size(); i++)
      chk($sformatf("%s_b%0d", tag, i), 32'(txq[i]), 32'(exp_q[i]));
    chk({tag, "_done"}, 32'(dones - d0), 32'(exp_acc));
    chk({tag, "_fcnt"}, 32'(o_frame_cnt), 32'(exp_frame));
    chk({tag, "_dcnt"}, 32'(o_drop_cnt), 32'(exp_drop));
    chk({tag, "_b2b"}, 32'(b2b), 32'(0));
  endtask

  task automatic run_frame(input string tag);
    start_frame();
    finish_frame(tag);
  endtask

  task automatic mk_rand();
    int kind, n;
    logic [15:0] d;
    logic [7:0] t;
    kind = $urandom_range(0, 7);
    n    = $urandom_range(5, 16);
    d    = NODE;
    t    = 8'h01;
    case (kind)
      1: d = 16'hFFFF;
      2: t = 8'h03;
      3: d = 16'($urandom_range(2, 65534));
      4: t = ($urandom_range(0, 1) == 0) ? 8'h81 : 8'h83;
      5: t = 8'h02;
      6: n = $urandom_range(1, 4);
      7: n = $urandom_range(17, 20);
      default: ;
    endcase
    fr.delete();
    fr.push_back(d[15:8]);
    fr.push_back(d[7:0]);
    fr.push_back(8'($urandom));
    fr.push_back(8'($urandom));
    fr.push_back(t);
    while (fr.size() < n) fr.push_back(8'($urandom));
    while (fr.size() > n) void'(fr.pop_back());
  endtask

  initial begin
    int k;
    logic [7:0] w0;
    int stall_bad;
    i_rst    = 1'b1;
    i_wready = 1'b1;
    i_rdata  = 8'h00;
    repeat (3) @(negedge i_clk);
    chk("rst_busy", 32'(o_busy), 32'(0));
    chk("rst_rreq", 32'(o_rreq), 32'(0));
    chk("rst_wvalid", 32'(o_wvalid), 32'(0));
    chk("rst_done", 32'(o_done), 32'(0));
    chk("rst_wdata", 32'(o_wdata), 32'(0));
    chk("rst_fcnt", 32'(o_frame_cnt), 32'(0));
    chk("rst_dcnt", 32'(o_drop_cnt), 32'(0));
    i_rst = 1'b0;
    @(negedge i_clk);

    load_hex(128'h0001004201AABBCC, 8);
    run_frame("ping");
    load_hex(128'hFFFF000703, 5);
    run_frame("req");
    load_hex(128'h00050042011122, 7);
    run_frame("baddst");
    load_hex(128'h000100, 3);
    run_frame("short");
    load_hex(128'h0001004281, 5);
    run_frame("dir");

    load_hex(128'h0001004201, 5);
    repeat (12) fr.push_back(8'($urandom));
    run_frame("ovf17");
    load_hex(128'hFFFF003301, 5);
    repeat (11) fr.push_back(8'($urandom));
    run_frame("full16");

    load_hex(128'h0001001101, 5);
    repeat (5) fr.push_back(8'($urandom));
    start_frame();
    k = 0;
    while (rx_n > 6 && k < 500) begin
      @(negedge i_clk);
      k++;
    end
    rx_en = 1'b0;
    repeat (GAP - 1) @(negedge i_clk);
    rx_en = 1'b1;
    finish_frame("glitch");

    load_hex(128'hFFFF000903, 5);
    start_frame();
    k = 0;
    while (txq.size() < 1 && k < 500) begin
      @(negedge i_clk);
      k++;
    end
    i_wready = 1'b0;
    repeat (3) @(negedge i_clk);
    w0 = o_wdata;
    stall_bad = 0;
    repeat (17) begin
      @(negedge i_clk);
      if (o_wvalid !== 1'b0 || o_wdata !== w0) stall_bad++;
    end
    chk("stall_hold", 32'(stall_bad), 32'(0));
    i_wready = 1'b1;
    finish_frame("stall");

    load_hex(128'hFFFF004401, 5);
    repeat (7) fr.push_back(8'($urandom));
    start_frame();
    k = 0;
    while (txq.size() < 2 && k < 500) begin
      @(negedge i_clk);
      k++;
    end
    i_rst = 1'b1;
    @(negedge i_clk);
    chk("mrst_wvalid", 32'(o_wvalid), 32'(0));
    chk("mrst_busy", 32'(o_busy), 32'(0));
    chk("mrst_fcnt", 32'(o_frame_cnt), 32'(0));
    chk("mrst_dcnt", 32'(o_drop_cnt), 32'(0));
    chk("mrst_wdata", 32'(o_wdata), 32'(0));
    i_rst = 1'b0;
    exp_frame = 16'd0;
    exp_drop  = 8'd0;
    @(negedge i_clk);

    for (int i = 0; i < 14; i++) begin
      mk_rand();
      run_frame($sformatf("rnd%0d", i));
    end

    chk("tap", 32'(tap_bad), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mhp_frame_engine.md
Name: mhp_frame_engine

Overview:
- Parametrised successor of the MHP packet handler. Sits between the Ethernet RX payload FIFO, the TX byte port and the UART debug tap.
- Drains one received payload into a local byte buffer. The frame ends after an idle gap on i_rready.
- Parses the 5-byte MHP header, then sends a PING echo or a REQ_ADDR reply, or drops the frame.
- Adds configurable depth, idle gap and node address, plus address filtering, overflow/short-frame handling and statistics.

Parameters:
- BUF_AW, 10, buffer address width; depth is 2**BUF_AW bytes.
- IDLE_GAP, 63, consecutive cycles with i_rready low that end a frame (1..255).
- NODE_ADDR, 16'h0001, own node address.
- MIN_LEN, 5, minimum accepted frame length in bytes (header size).

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_rdata  in  8  RX FIFO data, valid the cycle after o_rreq
- i_rready  in  1  RX FIFO non-empty
- o_rreq  out  1  RX FIFO pop, one-cycle pulse
- o_wdata  out  8  TX byte
- i_wready  in  1  TX port can accept a byte
- o_wvalid  out  1  TX byte strobe, one-cycle pulse
- o_wvalid_u  out  1  UART tap strobe
- o_wdata_u  out  8  UART tap byte
- o_done  out  1  one-cycle pulse when a reply completes
- o_busy  out  1  high in any state other than IDLE
- o_frame_cnt  out  16  accepted frames, wraps
- o_drop_cnt  out  8  dropped frames, saturates at 8'hFF

Behaviour:
- Reset (synchronous, any state): state=IDLE. o_rreq, o_wvalid, o_wvalid_u, o_done and o_busy are 0 at the next edge. o_wdata, o_wdata_u and both counters are 0. Length and pointers are cleared. A partial frame is discarded and not counted as a drop.
- Header (big-endian): bytes 0-1 DST, 2-3 SRC, 4 TYPE. TYPE[7] is the direction (1 = reply); TYPE[6:0] is the code: 0x01 PING, 0x03 REQ_ADDR.
- RX FSM:
  - IDLE: when i_rready=1, pulse o_rreq and go to RD_CAP.
  - RD_CAP: write i_rdata to buf[len] if len < 2**BUF_AW, else set ovf. len++ saturates at 2**BUF_AW. Go to RD_GAP.
  - RD_GAP: gap counter clears on entry. If i_rready=1, pulse o_rreq and go to RD_CAP. Otherwise count; when the counter reaches IDLE_GAP, go to PARSE.
  - Sustained throughput: 1 byte per 2 cycles.
- PARSE (1 cycle; header registers loaded during RD_CAP of bytes 0-4). The frame is dropped (o_drop_cnt++, go to IDLE) when any of these holds:
  - ovf is set;
  - len < MIN_LEN;
  - TYPE[7]=1;
  - DST is neither NODE_ADDR nor 16'hFFFF;
  - code is unknown.
  Otherwise o_frame_cnt++ and go to TX.
- TX PING: echo all len bytes in order, except bytes 0-1 become the request SRC, bytes 2-3 become NODE_ADDR, and byte 4 becomes TYPE|8'h80.
- TX REQ_ADDR: send 9 bytes: SRC_hi, SRC_lo, NODE_hi, NODE_lo, 8'h83, 8'h00, 8'h02, NODE_hi, NODE_lo.
- TX handshake, per byte:
  - TX_FETCH: present the buffer address; read latency is 1.
  - TX_LOAD: latch the byte into o_wdata.
  - TX_SEND: wait for i_wready=1, then pulse o_wvalid for 1 cycle with o_wdata stable in that cycle.
  - Back to TX_FETCH for the next byte, or TX_END after the last byte.
  - o_wvalid is never high in consecutive cycles.
- TX_END: pulse o_done, return to IDLE. Bytes arriving in the RX FIFO during TX are not popped; they wait for IDLE.
- i_rready glitching low for fewer than IDLE_GAP cycles does not split a frame.
- A frame of exactly 2**BUF_AW bytes is accepted. One byte more sets ovf, the remaining bytes are still drained, and the frame is dropped.

Optional Feature:
- Macro MHP_UART_TAP_EN.
- Defined: o_wvalid_u and o_wdata_u mirror o_wvalid and o_wdata cycle-exact.
- Undefined: o_wvalid_u and o_wdata_u are tied to 0 and no tap logic is generated.

Decomposition:
- Package mhp_pkg holds:
  - FSM state enum (IDLE, RD_CAP, RD_GAP, PARSE, TX_FETCH, TX_LOAD, TX_SEND, TX_END);
  - type codes TYPE_PING=7'h01 and TYPE_REQ_ADDR=7'h03;
  - DIR_REPLY bit index 7, BCAST_ADDR=16'hFFFF, HDR_LEN=5;
  - REQ_ADDR reply length 9 and reply type byte 8'h83.
- Sub-module mhp_byte_ram: single-port, 1-cycle-read byte RAM of depth 2**BUF_AW with write enable.

Test Plan:
- PING to NODE_ADDR=0x0001 from 0x0042 with 8 bytes {00 01 00 42 01 AA BB CC}, i_wready=1 -> TX {00 42 00 01 81 AA BB CC}, o_done pulses once, o_frame_cnt=1.
- REQ_ADDR to broadcast FFFF from 0x0007 -> TX {00 07 00 01 83 00 02 00 01} (9 strobes, none back-to-back).
- Frame to DST 0x0005, then a 3-byte frame, then a TYPE 0x81 frame -> no TX, o_drop_cnt=3.
- BUF_AW=4, 17-byte PING -> all 17 bytes popped, no TX, o_drop_cnt=1; a following 16-byte PING is echoed (16 bytes).
- i_rready low for IDLE_GAP-1 cycles mid-frame -> one frame. Hold i_wready=0 for 20 cycles during TX -> o_wvalid stays 0, o_wdata stable, sending resumes when i_wready rises.
- i_rst asserted mid-TX -> next cycle o_wvalid=0, o_busy=0, counters 0. With MHP_UART_TAP_EN defined the tap matches TX; undefined, the tap stays 0.
